rf_alu_sequencer: RTL and testbench

- Hardwired control sequencer that sits directly upstream of the bus datapath.
- Drives every control strobe the datapath consumes: fetch (T0–T2) and execute (T3–T6) for register-format ALU instructions, replacing hand-driven control waveforms.
- Decodes the instruction register, generates one-hot register in/out selects and the ALU operation code, and pauses T1 on a memory-ready handshake.

---
 rtl/rf_alu_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_sequencer.sv
// Hardwired fetch/execute control sequencer for register-format ALU instructions.
// Moore FSM: every strobe is a decode of the registered state plus the IR fields.
module rf_alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        LOin,
  output logic        HIin,
  output logic        read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  operation,
  output logic        run,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    C_3REG    = 2'd0,
    C_MULDIV  = 2'd1,
    C_UNARY   = 2'd2,
    C_ILLEGAL = 2'd3
  } class_t;

  function automatic class_t op_class(input logic [4:0] op);
    class_t c;
    if ((op >= 5'd3) && (op <= 5'd11)) begin
      c = C_3REG;
    end else if ((op == 5'd15) || (op == 5'd16)) begin
      c = C_MULDIV;
    end else if ((op == 5'd17) || (op == 5'd18)) begin
      c = C_UNARY;
    end else begin
      c = C_ILLEGAL;
    end
    return c;
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

  state_t     state_r;
  state_t     state_s;
  logic       illegal_r;
  logic       illegal_s;
  class_t     cls_s;
  logic [4:0] op_s;
  logic [3:0] ra_s;
  logic [3:0] rb_s;
  logic [3:0] rc_s;
  logic       unused_ir_s;

  assign op_s        = ir[31:27];
  assign ra_s        = ir[26:23];
  assign rb_s        = ir[22:19];
  assign rc_s        = ir[18:15];
  assign unused_ir_s = ^ir[14:0];
  assign cls_s       = op_class(op_s);
  assign illegal     = illegal_r;

  // State and sticky illegal flag; clear drops both asynchronously.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r   <= S_IDLE;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      illegal_r <= illegal_s;
    end
  end

  // Next-state: T1 waits on mem_rdy, stop is honoured only at instruction boundaries.
  always_comb begin
    state_s   = state_r;
    illegal_s = illegal_r;
    case (state_r)
      S_IDLE: begin
        if (stop) state_s = S_HALT;
        else      state_s = S_T0;
      end
      S_T0: state_s = S_T1;
      S_T1: begin
        if (mem_rdy) state_s = S_T2;
        else         state_s = S_T1;
      end
      S_T2: state_s = S_T3;
      S_T3: begin
        if (cls_s == C_ILLEGAL) begin
          state_s   = S_HALT;
          illegal_s = 1'b1;
        end else begin
          state_s = S_T4;
        end
      end
      S_T4: state_s = S_T5;
      S_T5: begin
        if (cls_s == C_MULDIV) state_s = S_T6;
        else if (stop)         state_s = S_HALT;
        else                   state_s = S_T0;
      end
      S_T6: begin
        if (stop) state_s = S_HALT;
        else      state_s = S_T0;
      end
      S_HALT: begin
        if (illegal_r)  state_s = S_HALT;
        else if (stop)  state_s = S_HALT;
        else            state_s = S_T0;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Strobe decode; anything not named for a state stays low.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zhighin    = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    read       = 1'b0;
    Rin        = 16'h0000;
    Rout       = 16'h0000;
    operation  = 5'd0;
    run        = 1'b0;
    instr_done = 1'b0;
    case (state_r)
      S_T0: begin
        run    = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        run    = 1'b1;
        ZLOout = 1'b1;
        PCin   = 1'b1;
        read   = 1'b1;
        MDRin  = 1'b1;
      end
      S_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        case (cls_s)
          C_3REG, C_UNARY: begin
            Rout = onehot16(rb_s);
            Yin  = 1'b1;
          end
          C_MULDIV: begin
            Rout = onehot16(ra_s);
            Yin  = 1'b1;
          end
          default: Yin = 1'b0;
        endcase
      end
      S_T4: begin
        run       = 1'b1;
        operation = op_s;
        Zlowin    = 1'b1;
        case (cls_s)
          C_3REG:  Rout = onehot16(rc_s);
          C_UNARY: Rout = onehot16(rb_s);
          C_MULDIV: begin
            Rout    = onehot16(rb_s);
            Zhighin = 1'b1;
          end
          default: Rout = 16'h0000;
        endcase
      end
      S_T5: begin
        run    = 1'b1;
        ZLOout = 1'b1;
        if (cls_s == C_MULDIV) begin
          LOin = 1'b1;
        end else begin
          Rin        = onehot16(ra_s);
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        run        = 1'b1;
        ZHIout     = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer: a step-counting instruction model checked every
// cycle, plus literal expectations taken from hand-decoded instruction words.
module tb_rf_alu_sequencer;

  localparam logic [31:0] IR_SHR = 32'h389A8000;
  localparam logic [31:0] IR_MUL = 32'h79200000;
  localparam logic [31:0] IR_ILL = 32'hF8000000;
  localparam logic [31:0] IR_UN  = {5'b10001, 4'd7, 4'd9, 4'd0, 15'd0};

  typedef struct packed {
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, ZLOout, ZHIout, LOin, HIin, read;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  operation;
    logic run, instr_done, illegal;
  } outs_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        stop;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, ZLOout, ZHIout, LOin, HIin, read;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  operation;
  logic run, instr_done, illegal;

  int checks = 0;
  int errors = 0;

  rf_alu_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .LOin(LOin), .HIin(HIin), .read(read),
    .Rin(Rin), .Rout(Rout), .operation(operation), .run(run),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  outs_t dut_o;
  assign dut_o = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
                  Zlowin, Zhighin, ZLOout, ZHIout, LOin, HIin, read,
                  Rin, Rout, operation, run, instr_done, illegal};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running (m_step = cycle within instruction), 2 halted.
  int m_mode = 0;
  int m_step = 0;
  bit m_ill  = 1'b0;

  function automatic bit is_md(input logic [31:0] w);
    return (w[31:27] == 5'd15) || (w[31:27] == 5'd16);
  endfunction
  function automatic bit is_3r(input logic [31:0] w);
    return (w[31:27] >= 5'd3) && (w[31:27] <= 5'd11);
  endfunction
  function automatic bit is_un(input logic [31:0] w);
    return (w[31:27] == 5'd17) || (w[31:27] == 5'd18);
  endfunction

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_mode <= 0;
      m_step <= 0;
      m_ill  <= 1'b0;
    end else if (m_mode == 0) begin
      m_mode <= stop ? 2 : 1;
      m_step <= 0;
    end else if (m_mode == 2) begin
      if (!m_ill && !stop) begin
        m_mode <= 1;
        m_step <= 0;
      end
    end else begin
      if (m_step == 1 && !mem_rdy) begin
        m_step <= 1;
      end else if (m_step == 3 && !(is_md(ir) || is_3r(ir) || is_un(ir))) begin
        m_mode <= 2;
        m_ill  <= 1'b1;
      end else if (m_step == (is_md(ir) ? 6 : 5)) begin
        if (stop) m_mode <= 2;
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  function automatic outs_t model_outs();
    outs_t o;
    bit legal;
    o = '0;
    o.illegal = m_ill;
    legal = is_md(ir) || is_3r(ir) || is_un(ir);
    if (m_mode == 1) begin
      o.run = 1'b1;
      if (m_step == 0) begin
        o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zlowin = 1'b1;
      end else if (m_step == 1) begin
        o.ZLOout = 1'b1; o.PCin = 1'b1; o.read = 1'b1; o.MDRin = 1'b1;
      end else if (m_step == 2) begin
        o.MDRout = 1'b1; o.IRin = 1'b1;
      end else if (m_step == 3 && legal) begin
        o.Yin  = 1'b1;
        o.Rout = 16'd1 << (is_md(ir) ? ir[26:23] : ir[22:19]);
      end else if (m_step == 4) begin
        o.operation = ir[31:27];
        o.Zlowin    = 1'b1;
        o.Zhighin   = is_md(ir);
        o.Rout      = 16'd1 << (is_3r(ir) ? ir[18:15] : ir[22:19]);
      end else if (m_step == 5) begin
        o.ZLOout = 1'b1;
        if (is_md(ir)) o.LOin = 1'b1;
        else begin
          o.Rin        = 16'd1 << ir[26:23];
          o.instr_done = 1'b1;
        end
      end else if (m_step == 6) begin
        o.ZHIout = 1'b1; o.HIin = 1'b1; o.instr_done = 1'b1;
      end
    end
    return o;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("model_cycle", 64'(dut_o), 64'(model_outs()));
  end

  initial begin
    clear = 1'b0; stop = 1'b0; mem_rdy = 1'b1; ir = IR_SHR;
    repeat (2) @(negedge clock);
    chk("reset_all_zero", 64'(dut_o), 64'd0);
    #1 clear = 1'b1;

    // shr R1,R3,R5 with no wait states
    @(negedge clock);
    chk("shr_t0_pcout", 64'(PCout), 64'd1);
    repeat (3) @(negedge clock);
    chk("shr_t3_rout", 64'(Rout), 64'h0008);
    chk("shr_t3_yin", 64'(Yin), 64'd1);
    @(negedge clock);
    chk("shr_t4_rout", 64'(Rout), 64'h0020);
    chk("shr_t4_op", 64'(operation), 64'd7);
    chk("shr_t4_zlowin", 64'(Zlowin), 64'd1);
    @(negedge clock);
    chk("shr_t5", 64'({ZLOout, instr_done, Rin}), 64'h3_0002);
    @(negedge clock);
    chk("shr_next_t0", 64'({PCout, run}), 64'd3);

    // three memory wait cycles stretch T1 to four cycles
    #1 mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t1_wait_strobes", 64'({read, MDRin, PCin, ZLOout}), 64'hF);
      if (i == 3) #1 mem_rdy = 1'b1;
    end
    @(negedge clock);
    chk("t2_after_wait", 64'({MDRout, IRin, read}), 64'd6);
    repeat (4) @(negedge clock);

    // mul R2,R4
    #1 ir = IR_MUL;
    repeat (3) @(negedge clock);
    chk("mul_t3_rout", 64'(Rout), 64'h0004);
    @(negedge clock);
    chk("mul_t4_rout", 64'(Rout), 64'h0010);
    chk("mul_t4_z", 64'({Zlowin, Zhighin}), 64'd3);
    chk("mul_t4_op", 64'(operation), 64'd15);
    @(negedge clock);
    chk("mul_t5", 64'({LOin, instr_done}), 64'd2);
    @(negedge clock);
    chk("mul_t6", 64'({HIin, instr_done}), 64'd3);
    @(negedge clock);

    // illegal opcode 11111
    #1 ir = IR_ILL;
    repeat (3) @(negedge clock);
    chk("ill_t3_quiet", 64'({Rout, Yin, run, illegal}), 64'd2);
    @(negedge clock);
    chk("ill_halt", 64'({run, illegal}), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("ill_stays_halt", 64'({run, illegal}), 64'd1);
    end
    #1 clear = 1'b0;
    #1 chk("ill_cleared", 64'({run, illegal}), 64'd0);
    ir = IR_SHR;
    @(negedge clock);
    #1 clear = 1'b1;
    chk("idle_after_clear", 64'(dut_o), 64'd0);

    // stop raised during T4 takes effect at the boundary
    @(negedge clock);
    chk("stop_t0", 64'(PCout), 64'd1);
    repeat (4) @(negedge clock);
    #1 stop = 1'b1;
    @(negedge clock);
    chk("stop_t5_rin", 64'({instr_done, Rin}), 64'h1_0002);
    @(negedge clock);
    chk("stop_halt", 64'({run, illegal}), 64'd0);
    #1 stop = 1'b0;
    @(negedge clock);
    chk("resume_t0", 64'({PCout, run}), 64'd3);

    // asynchronous clear in the middle of T4
    repeat (4) @(negedge clock);
    chk("pre_clear_t4", 64'({Zlowin, run}), 64'd3);
    #2 clear = 1'b0;
    #1 chk("async_clear", 64'({Rout, operation, Zlowin, run}), 64'd0);
    @(negedge clock);
    #1 clear = 1'b1;
    chk("idle_after_async", 64'(dut_o), 64'd0);
    @(negedge clock);
    chk("async_resume_t0", 64'(PCout), 64'd1);

    // unary R7 <- f(R9), then halt at the boundary
    #1 ir = IR_UN;
    repeat (3) @(negedge clock);
    chk("un_t3_rout", 64'(Rout), 64'h0200);
    repeat (2) @(negedge clock);
    chk("un_t5_rin", 64'({instr_done, Rin}), 64'h1_0080);
    #1 stop = 1'b1;
    repeat (3) @(negedge clock);
    chk("un_final_halt", 64'({run, illegal}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
